// File: rtl/video_pkg.sv
// Shared video-path helpers: packing ratio, slot offsets, default pixel/word types.
package video_pkg;

  localparam int PIXEL_BIT_DEF  = 15;
  localparam int PACK_BIT_DEF   = 64;
  localparam int FIFO_WIDTH_DEF = 11;

  typedef logic [PIXEL_BIT_DEF-1:0] pixel_t;
  typedef logic [PACK_BIT_DEF-1:0]  word_t;

  function automatic int pack_div(input int pack_bit, input int pixel_bit);
    return pack_bit / pixel_bit;
  endfunction

  function automatic int slot_lsb(input int slot, input int pixel_bit);
    return slot * pixel_bit;
  endfunction

  // Slot counter width; at least one bit even for a two-slot word.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/pack_accum.sv
// Pixel-to-word accumulator: LSB-first slot fill, full-word and end-of-line flush detect.
// Combinational word/strobes, registered slot state; padding mode set by DATA_PACK_PAD_REPLICATE_EN.
module pack_accum
  import video_pkg::*;
#(
  parameter int PIXEL_BIT = 15,
  parameter int PACK_BIT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic [PIXEL_BIT-1:0] pixel,
  input  logic                 eol,
  output logic                 full,
  output logic                 flush,
  output logic [PACK_BIT-1:0]  word
);

  localparam int DIV = pack_div(PACK_BIT, PIXEL_BIT);
  localparam int CW  = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0]        pcnt;
  logic [PACK_BIT-1:0]  acc;
  logic [PACK_BIT-1:0]  filled;
  logic [PACK_BIT-1:0]  padded;
  logic [PIXEL_BIT-1:0] pad_px;

`ifdef DATA_PACK_PAD_REPLICATE_EN
  logic [PIXEL_BIT-1:0] last_px;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_px <= '0;
    end else if (accept) begin
      last_px <= pixel;
    end
  end

  assign pad_px = last_px;
`else
  assign pad_px = '0;
`endif

  always_comb begin
    filled = acc;
    padded = acc;
    for (int k = 0; k < DIV; k++) begin
      if (accept && pcnt == CW'(k)) begin
        filled[slot_lsb(k, PIXEL_BIT) +: PIXEL_BIT] = pixel;
      end
      if (CW'(k) >= pcnt) begin
        padded[slot_lsb(k, PIXEL_BIT) +: PIXEL_BIT] = pad_px;
      end
    end
  end

  assign full  = accept && (pcnt == LAST);
  assign flush = eol && (pcnt != '0);
  assign word  = full ? filled : padded;

  // Bits above the last slot are never written, so acc keeps them at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      acc  <= '0;
    end else if (full || eol) begin
      pcnt <= '0;
      acc  <= '0;
    end else if (accept) begin
      pcnt <= pcnt + 1'b1;
      acc  <= filled;
    end
  end

endmodule

// File: rtl/data_pack.sv
// Packs PACK_BIT/PIXEL_BIT pixels per word with word index, line count and 1-cycle sync delay.
// Word appears 1 cycle after its last pixel or after de falls; no backpressure; DATA_PACK_PAD_REPLICATE_EN selects flush padding.
module data_pack
  import video_pkg::*;
#(
  parameter int PIXEL_BIT  = 15,
  parameter int PACK_BIT   = 64,
  parameter int FIFO_WIDTH = 11
) (
  input  logic                  in_pclk,
  input  logic                  i_arst,
  input  logic [FIFO_WIDTH-1:0] in_x,
  input  logic [FIFO_WIDTH-1:0] in_y,
  input  logic                  in_valid,
  input  logic                  in_de,
  input  logic                  in_hs,
  input  logic                  in_vs,
  input  logic [PIXEL_BIT-1:0]  in_data,
  output logic [FIFO_WIDTH-1:0] out_x,
  output logic [FIFO_WIDTH-1:0] out_y,
  output logic                  out_valid,
  output logic                  out_de,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic [PACK_BIT-1:0]   out_data,
  output logic                  out_overflow
);

  localparam logic [FIFO_WIDTH-1:0] IDX_MAX = '1;

  logic                  accept;
  logic                  eol;
  logic                  eol_q;
  logic                  full;
  logic                  flush;
  logic [PACK_BIT-1:0]   word;
  logic [FIFO_WIDTH-1:0] widx;
  logic                  unused_coords;

  assign unused_coords = ^{in_x, in_y};
  assign accept        = in_valid && in_de;
  // out_de doubles as the previous-cycle de for edge detection.
  assign eol           = !in_de && out_de;

  pack_accum #(
    .PIXEL_BIT (PIXEL_BIT),
    .PACK_BIT  (PACK_BIT)
  ) u_accum (
    .clk    (in_pclk),
    .rst    (i_arst),
    .accept (accept),
    .pixel  (in_data),
    .eol    (eol),
    .full   (full),
    .flush  (flush),
    .word   (word)
  );

  always_ff @(posedge in_pclk or posedge i_arst) begin
    if (i_arst) begin
      out_x        <= '0;
      out_y        <= '0;
      out_valid    <= 1'b0;
      out_de       <= 1'b0;
      out_hs       <= 1'b0;
      out_vs       <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      widx         <= '0;
      eol_q        <= 1'b0;
    end else begin
      out_de    <= in_de;
      out_hs    <= in_hs;
      out_vs    <= in_vs;
      out_valid <= full || flush;
      eol_q     <= eol;
      if (full || flush) begin
        out_data <= word;
        out_x    <= widx;
      end
      if (eol) begin
        widx <= '0;
      end else if (full) begin
        if (widx == IDX_MAX) begin
          out_overflow <= 1'b1;
        end else begin
          widx <= widx + 1'b1;
        end
      end
      // Increment one cycle late so a flush word still carries the old line number.
      if (!in_vs) begin
        out_y <= '0;
      end else if (eol_q) begin
        out_y <= out_y + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_pack.sv
// Scoreboard bench for data_pack: model pushes expected words, negedge monitor pops and compares.
module tb_data_pack;
  import video_pkg::*;

  localparam int PB  = 15;
  localparam int WB  = 64;
  localparam int FW  = 11;
  localparam int DIV = WB / PB;

  typedef struct packed {
    logic [WB-1:0] data;
    logic [FW-1:0] x;
    logic [FW-1:0] y;
    int            cyc;
  } exp_t;

  logic          in_pclk = 1'b0;
  logic          i_arst;
  logic [FW-1:0] in_x, in_y;
  logic          in_valid, in_de, in_hs, in_vs;
  logic [PB-1:0] in_data;

  logic [FW-1:0] out_x, out_y;
  logic          out_valid, out_de, out_hs, out_vs, out_overflow;
  logic [WB-1:0] out_data;

  logic [2:0]    s_out_x, s_out_y;
  logic          s_out_valid, s_out_de, s_out_hs, s_out_vs, s_out_overflow;
  logic [WB-1:0] s_out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t       sb[$];
  logic [2:0] s_xq[$];
  logic       s_track = 1'b0;

  logic [WB-1:0] m_acc;
  int            m_pcnt;
  logic [FW-1:0] m_widx, m_y;
  pixel_t        m_last;

  always #5 in_pclk = ~in_pclk;
  always @(posedge in_pclk) cyc++;

  data_pack #(.PIXEL_BIT(PB), .PACK_BIT(WB), .FIFO_WIDTH(FW)) dut (
    .in_pclk(in_pclk), .i_arst(i_arst), .in_x(in_x), .in_y(in_y),
    .in_valid(in_valid), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_data(in_data),
    .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_de(out_de),
    .out_hs(out_hs), .out_vs(out_vs), .out_data(out_data), .out_overflow(out_overflow)
  );

  data_pack #(.PIXEL_BIT(PB), .PACK_BIT(WB), .FIFO_WIDTH(3)) dut_small (
    .in_pclk(in_pclk), .i_arst(i_arst), .in_x(in_x[2:0]), .in_y(in_y[2:0]),
    .in_valid(in_valid), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_data(in_data),
    .out_x(s_out_x), .out_y(s_out_y), .out_valid(s_out_valid), .out_de(s_out_de),
    .out_hs(s_out_hs), .out_vs(s_out_vs), .out_data(s_out_data), .out_overflow(s_out_overflow)
  );

  always @(negedge in_pclk) begin
    exp_t e;
    if (!i_arst && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got data=%h x=%0d y=%0d, none expected", out_data, out_x, out_y);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_x !== e.x || out_y !== e.y || cyc != e.cyc) begin
          errors++;
          $display("FAIL word got data=%h x=%0d y=%0d cyc=%0d expected data=%h x=%0d y=%0d cyc=%0d",
                   out_data, out_x, out_y, cyc, e.data, e.x, e.y, e.cyc);
        end
      end
    end
    if (s_track && s_out_valid) s_xq.push_back(s_out_x);
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_acc = '0; m_pcnt = 0; m_widx = '0; m_y = '0; m_last = '0;
  endtask

  task automatic model_pixel(input pixel_t pix);
    m_acc[m_pcnt*PB +: PB] = pix;
    m_last = pix;
    m_pcnt++;
    if (m_pcnt == DIV) begin
      sb.push_back('{data: m_acc, x: m_widx, y: m_y, cyc: cyc + 1});
      m_acc = '0;
      m_pcnt = 0;
      if (m_widx != '1) m_widx++;
    end
  endtask

  task automatic model_eol();
    if (m_pcnt != 0) begin
      for (int k = m_pcnt; k < DIV; k++) begin
`ifdef DATA_PACK_PAD_REPLICATE_EN
        m_acc[k*PB +: PB] = m_last;
`else
        m_acc[k*PB +: PB] = '0;
`endif
      end
      sb.push_back('{data: m_acc, x: m_widx, y: m_y, cyc: cyc + 1});
    end
    m_acc = '0; m_pcnt = 0; m_widx = '0; m_y++;
  endtask

  task automatic drive_pixel(input pixel_t pix);
    @(negedge in_pclk);
    in_valid = 1'b1; in_de = 1'b1; in_data = pix;
    model_pixel(pix);
  endtask

  task automatic drive_gap();
    @(negedge in_pclk);
    in_valid = 1'b0; in_de = 1'b1;
  endtask

  task automatic end_line();
    @(negedge in_pclk);
    in_valid = 1'b0; in_de = 1'b0;
    model_eol();
    repeat (3) @(negedge in_pclk);
  endtask

  task automatic send_line(input int n, input int base);
    for (int i = 0; i < n; i++) drive_pixel(pixel_t'(base + i));
    end_line();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge in_pclk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    in_x = '0; in_y = '0; in_valid = 1'b0; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; in_data = '0;
    repeat (3) @(negedge in_pclk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h required 0", out_data); end
    checks++; if (out_x !== '0 || out_y !== '0) begin errors++; $display("FAIL reset_xy got %0d/%0d required 0/0", out_x, out_y); end
    checks++; if ({out_de, out_hs, out_vs, out_overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_sync got %b required 0000", {out_de, out_hs, out_vs, out_overflow});
    end
    i_arst = 1'b0;
    in_vs = 1'b1;
    model_reset();
    repeat (2) @(negedge in_pclk);
  endtask

  task automatic test_sync();
    @(negedge in_pclk); in_hs = 1'b1;
    @(negedge in_pclk);
    checks++; if (out_hs !== 1'b1 || out_vs !== 1'b1) begin errors++; $display("FAIL sync_delay got hs=%b vs=%b required 1/1", out_hs, out_vs); end
    in_hs = 1'b0;
    @(negedge in_pclk);
    checks++; if (out_hs !== 1'b0) begin errors++; $display("FAIL sync_hs_fall got %b required 0", out_hs); end
  endtask

  task automatic test_full_words();
    send_line(8, 1);
    wait_drain("full_words");
  endtask

  task automatic test_partial();
    send_line(6, 'h11);
    wait_drain("partial");
  endtask

  task automatic test_gapped();
    repeat (2) begin
      @(negedge in_pclk);
      in_valid = 1'b1; in_de = 1'b0; in_data = 15'h7FFF;
    end
    for (int i = 0; i < 8; i++) begin
      drive_pixel(pixel_t'('h41 + i));
      drive_gap();
    end
    end_line();
    wait_drain("gapped");
  endtask

  task automatic test_frame();
    @(negedge in_pclk); in_vs = 1'b0;
    @(negedge in_pclk);
    m_y = '0;
    checks++; if (out_y !== '0) begin errors++; $display("FAIL frame_clear got y=%0d required 0", out_y); end
    in_vs = 1'b1;
    for (int l = 0; l < 3; l++) send_line(5, 'h100 + 16 * l);
    wait_drain("frame");
    checks++; if (out_y !== 11'd3) begin errors++; $display("FAIL frame_count got y=%0d required 3", out_y); end
    @(negedge in_pclk); in_vs = 1'b0;
    @(negedge in_pclk);
    m_y = '0;
    checks++; if (out_y !== '0) begin errors++; $display("FAIL frame_vs_clear got y=%0d required 0", out_y); end
    in_vs = 1'b1;
    send_line(4, 'h200);
    wait_drain("frame_next");
  endtask

  task automatic test_overflow();
    checks++; if (s_out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_initial got %b required 0", s_out_overflow); end
    s_xq.delete();
    s_track = 1'b1;
    send_line(40, 'h300);
    wait_drain("ovf_main");
    s_track = 1'b0;
    checks++;
    if (s_xq.size() != 10) begin
      errors++; $display("FAIL ovf_words got %0d required 10", s_xq.size());
    end else begin
      checks++; if (s_xq[6] !== 3'd6) begin errors++; $display("FAIL ovf_idx6 got %0d required 6", s_xq[6]); end
      checks++; if (s_xq[8] !== 3'd7 || s_xq[9] !== 3'd7) begin
        errors++; $display("FAIL ovf_sat got %0d/%0d required 7/7", s_xq[8], s_xq[9]);
      end
    end
    checks++; if (s_out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b required 1", s_out_overflow); end
    send_line(4, 'h400);
    wait_drain("ovf_after");
    checks++; if (s_out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", s_out_overflow); end
  endtask

  task automatic test_reset_midline();
    @(negedge in_pclk); in_valid = 1'b1; in_de = 1'b1; in_data = 15'h21;
    @(negedge in_pclk); in_data = 15'h22;
    @(negedge in_pclk);
    in_valid = 1'b0; in_de = 1'b0;
    i_arst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_x !== '0 || out_y !== '0) begin
      errors++; $display("FAIL arst_outputs got v=%b d=%h x=%0d y=%0d required all 0", out_valid, out_data, out_x, out_y);
    end
    checks++; if ({out_de, out_hs, out_vs, s_out_overflow} !== 4'b0) begin
      errors++; $display("FAIL arst_sync got %b required 0000", {out_de, out_hs, out_vs, s_out_overflow});
    end
    @(negedge in_pclk);
    i_arst = 1'b0;
    model_reset();
    repeat (4) @(negedge in_pclk);
    send_line(4, 'h31);
    wait_drain("arst_next");
  endtask

  initial begin
    test_reset();
    test_sync();
    test_full_words();
    test_partial();
    test_gapped();
    test_frame();
    test_overflow();
    test_reset_midline();
    repeat (3) @(negedge in_pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
